// File: rtl/mem_pkg.sv
// Shared definitions for the cache refill responder: bus widths, block
// geometry and the controller state encoding.
package mem_pkg;

    localparam int ADDR_W      = 15;
    localparam int DATA_W      = 32;
    localparam int BLOCK_WORDS = 4;
    localparam int OFFS_W      = 2;

    // Legacy-compatible state codes, reused as the enum values below
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_RD_WAIT = 2'd1;
    localparam logic [1:0] ST_BURST   = 2'd2;
    localparam logic [1:0] ST_WR_WAIT = 2'd3;

    typedef enum logic [1:0] {
        IDLE    = ST_IDLE,
        RD_WAIT = ST_RD_WAIT,
        BURST   = ST_BURST,
        WR_WAIT = ST_WR_WAIT
    } state_e;

endpackage

// File: rtl/mem_refill_responder_if.sv
// Cache-side request/response bus of the refill responder.
// master = cache, slave = responder.
interface mem_refill_responder_if;
    import mem_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic [OFFS_W-1:0] rsp_idx;
    logic              rsp_last;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_idx, rsp_last
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_idx, rsp_last
    );

endinterface

// File: rtl/mem_array.sv
// Single-port backing store: synchronous write, registered (one-cycle) read.
// Contents are never reset.
module mem_array
    import mem_pkg::*;
#(
    parameter int DEPTH = 32768,
    parameter int AW    = 15
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Write when enabled; read the addressed word every cycle (read-first)
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/mem_refill_responder.sv
// Memory-side responder for cache refills and single-word writes.
// Reads return a 4-word block critical-word-first after LATENCY cycles;
// writes commit LATENCY cycles after acceptance and produce no response.
// Optional feature: define MEM_REQ_STATS_EN to add saturating rd_count /
// wr_count request counters as extra output ports.
module mem_refill_responder
    import mem_pkg::*;
#(
    parameter int LATENCY     = 4,
    parameter int DEPTH       = 32768,
    parameter int BLOCK_WORDS = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    mem_refill_responder_if.slave    bus,
    output logic                     busy
`ifdef MEM_REQ_STATS_EN
    ,
    output logic [ADDR_W-1:0]        rd_count,
    output logic [ADDR_W-1:0]        wr_count
`endif
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    state_e                   state;
    logic [3:0]               lat_cnt;
    logic [OFFS_W-1:0]        sent;
    logic [ADDR_W-OFFS_W-1:0] base;
    logic [OFFS_W-1:0]        offs;
    logic [DATA_W-1:0]        wr_data;

    logic                     accept;
    logic                     rsp_hs;
    logic                     in_burst;
    logic                     last_word;
    logic [OFFS_W-1:0]        rd_offs;
    logic [ADDR_W-1:0]        mem_addr;
    logic [AW-1:0]            mem_idx;
    logic                     mem_we;
    logic [DATA_W-1:0]        mem_rdata;

    assign in_burst  = (state == BURST);
    assign accept    = bus.req_valid && (state == IDLE);
    assign rsp_hs    = in_burst && bus.rsp_ready;
    assign last_word = (sent == OFFS_W'(BLOCK_WORDS - 1));

    // Responses are gated by state so reset clears them without touching the store
    assign bus.req_ready = (state == IDLE);
    assign bus.rsp_valid = in_burst;
    assign bus.rsp_data  = in_burst ? mem_rdata : '0;
    assign bus.rsp_idx   = in_burst ? offs : '0;
    assign bus.rsp_last  = in_burst && last_word;
    assign busy          = (state != IDLE);

    // On a handshake the store is already fetching the next word, so bursts have no gaps;
    // without one the current word is re-read and the output holds steady.
    assign rd_offs  = rsp_hs ? offs + OFFS_W'(1) : offs;
    assign mem_addr = {base, rd_offs};
    assign mem_idx  = AW'(32'(mem_addr) % 32'(DEPTH));
    assign mem_we   = (state == WR_WAIT) && (lat_cnt == 4'd0);

    mem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk   (clk),
        .we    (mem_we),
        .addr  (mem_idx),
        .wdata (wr_data),
        .rdata (mem_rdata)
    );

    // Controller: accept in IDLE, wait LATENCY edges, then stream or commit
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            lat_cnt <= 4'd0;
            sent    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state   <= bus.req_we ? WR_WAIT : RD_WAIT;
                        lat_cnt <= 4'(LATENCY - 1);
                        sent    <= '0;
                    end
                end
                RD_WAIT: begin
                    if (lat_cnt == 4'd0) begin
                        state <= BURST;
                    end else begin
                        lat_cnt <= lat_cnt - 4'd1;
                    end
                end
                WR_WAIT: begin
                    if (lat_cnt == 4'd0) begin
                        state <= IDLE;
                    end else begin
                        lat_cnt <= lat_cnt - 4'd1;
                    end
                end
                BURST: begin
                    if (rsp_hs) begin
                        if (last_word) begin
                            state <= IDLE;
                        end else begin
                            sent <= sent + OFFS_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Request address/data capture and burst offset walk (datapath, not reset)
    always_ff @(posedge clk) begin
        if (accept) begin
            {base, offs} <= bus.req_addr;
            wr_data      <= bus.req_wdata;
        end else if (rsp_hs) begin
            offs <= offs + OFFS_W'(1);
        end
    end

`ifdef MEM_REQ_STATS_EN
    function automatic logic [ADDR_W-1:0] sat_inc(input logic [ADDR_W-1:0] v);
        return (&v) ? v : v + ADDR_W'(1);
    endfunction

    // Count accepted reads and writes, sticking at the maximum value
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_count <= '0;
            wr_count <= '0;
        end else if (accept) begin
            if (bus.req_we) begin
                wr_count <= sat_inc(wr_count);
            end else begin
                rd_count <= sat_inc(rd_count);
            end
        end
    end
`endif

endmodule

// File: doc/mem_refill_responder.md
MEM_REFILL_RESPONDER -- requirements
Module: mem_refill_responder

Interface
REQ-001 Parameter LATENCY, default 4, SHALL set cycles from request acceptance to first response word or write commit; legal range 1..15.
REQ-002 Parameter DEPTH, default 32768, SHALL set the number of 32-bit words in the backing store.
REQ-003 Parameter BLOCK_WORDS, default 4, SHALL set the refill block size in words; fixed at 4.
REQ-004 clk  input  1  SHALL be the single clock; all state updates on the rising edge.
REQ-005 rst  input  1  SHALL be the reset: asynchronous, active-low (0 = reset).
REQ-006 req_valid  input  1  SHALL flag a cache request.
REQ-007 req_ready  output  1  SHALL flag that the block accepts a request this cycle.
REQ-008 req_we  input  1  SHALL select single-word write (1) or block refill read (0).
REQ-009 req_addr  input  15  SHALL carry the word address.
REQ-010 req_wdata  input  32  SHALL carry write data.
REQ-011 rsp_valid  output  1  SHALL flag a valid refill word.
REQ-012 rsp_ready  input  1  SHALL flag that the cache consumes the refill word.
REQ-013 rsp_data  output  32  SHALL carry the refill word.
REQ-014 rsp_idx  output  2  SHALL carry the word offset of rsp_data within the block.
REQ-015 rsp_last  output  1  SHALL mark the fourth and final word of a refill.
REQ-016 busy  output  1  SHALL be high in every state except IDLE.

Function
REQ-017 States SHALL be IDLE, RD_WAIT, BURST, WR_WAIT; req_ready SHALL be high only in IDLE.
REQ-018 Handshake on edge N with req_we=0 SHALL latch block base (req_addr[14:2]) and start offset (req_addr[1:0]) and enter RD_WAIT.
REQ-019 RD_WAIT SHALL count LATENCY edges; rsp_valid SHALL first be high in the cycle after edge N+LATENCY (state BURST).
REQ-020 BURST SHALL return words critical-word-first, offset wrapping modulo 4 (start 3 -> offsets 3,0,1,2).
REQ-021 rsp_data, rsp_idx, rsp_last SHALL stay stable while rsp_valid=1 and rsp_ready=0.
REQ-022 Each rsp_valid&rsp_ready edge SHALL advance one word with no gap cycles; handshake on rsp_last SHALL return to IDLE, req_ready high the next cycle.
REQ-023 Handshake on edge N with req_we=1 SHALL latch address and data, enter WR_WAIT, commit the word at edge N+LATENCY, then enter IDLE; writes SHALL produce no response.
REQ-024 A refill accepted after a write commit to the same address SHALL return the written data.
REQ-025 Addresses SHALL index the store modulo DEPTH; no error signalling.
REQ-026 Requests arriving while req_ready=0 SHALL be ignored, not queued.

Reset
REQ-027 rst=0 SHALL immediately force IDLE, rsp_valid=0, rsp_last=0, rsp_idx=0, rsp_data=0, busy=0, req_ready=1 once rst=1, and clear the latency counter.
REQ-028 Reset mid-refill SHALL abandon the burst; reset during WR_WAIT SHALL drop the pending write; store contents SHALL NOT be reset.

Configuration
REQ-029 With macro MEM_REQ_STATS_EN defined, outputs rd_count and wr_count (15 bits each, reset 0) SHALL increment on each accepted read/write request and saturate at 32767; without it those ports and counters SHALL NOT exist.

Structure
REQ-030 Package mem_pkg SHALL hold ADDR_W=15, DATA_W=32, BLOCK_WORDS=4, OFFS_W=2 and the state enum.
REQ-031 Backing store SHALL be a sub-module mem_array: single-port, synchronous write, one-cycle read, DEPTH x 32.

Verification
REQ-032 Store preloaded word k = 0xA000_0000+k; read req_addr=0x0400, LATENCY=4, rsp_ready=1 -> first rsp_valid 4 cycles after accept, words 0xA0000400..0xA0000403, idx 0..3, rsp_last on 4th.
REQ-033 Read req_addr=0x0403 -> idx sequence 3,0,1,2, data 0xA0000403,0xA0000400,0xA0000401,0xA0000402.
REQ-034 rsp_ready low 3 cycles on 2nd word -> rsp_data/idx held constant, no word lost or duplicated.
REQ-035 Write 0x0401 <- 0xDEADBEEF, then read 0x0400 -> 2nd word 0xDEADBEEF; req_ready low exactly LATENCY cycles after write accept.
REQ-036 rst=0 asserted during 2nd burst word -> rsp_valid 0 immediately, busy 0, next read after release returns correct block.
REQ-037 With MEM_REQ_STATS_EN: 3 reads and 2 writes -> rd_count=3, wr_count=2; forced count 32767 plus one read stays 32767.
